// File: rtl/fixed_point_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fixed_point_addsub_pipe
//   Pipelined two's-complement fixed-point adder/subtractor. The carry chain
//   is split into CHUNK-bit slices, with one slice per register stage. Each
//   stage adds its slice plus the carry registered by the stage before it.
//   The operands travel down the pipe with the data, so higher slices are
//   consumed later. The last stage detects signed overflow and, when SATURATE
//   is set, clamps the result.
//
//   Flow control is valid/ready. A stage loads when it is empty or when its
//   content moves on. Bubbles therefore collapse, and the pipe sustains one
//   result per cycle.
//
// Parameters
//   WIDTH     operand/result width (signed, Q(WIDTH-FRAC_BITS).FRAC_BITS)
//   FRAC_BITS fractional bits; the binary point does not affect the arithmetic
//   CHUNK     carry-chain bits per stage; WIDTH must be a multiple of CHUNK
//   SATURATE  1: clamp on signed overflow, 0: wrap modulo 2^WIDTH
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake (addend1, addend2, sub)
//   addend1, addend2    signed operands A and B
//   sub                 0: A+B, 1: A-B
//   out_valid/out_ready result handshake (sum, carry_out, overflow)
//   sum                 result, saturated or wrapped
//   carry_out           raw carry out of the MSB (unsigned view, pre-saturation)
//   overflow            signed overflow occurred on this result
// -----------------------------------------------------------------------------
module fixed_point_addsub_pipe #(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 32,
    parameter int CHUNK     = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] addend1,
    input  logic [WIDTH-1:0] addend2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSTAGE = WIDTH / CHUNK;
    localparam int LAST   = NSTAGE - 1;

    generate
        if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("fixed_point_addsub_pipe: WIDTH must be a non-zero multiple of CHUNK");
        end
        if (FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_frac
            $error("fixed_point_addsub_pipe: FRAC_BITS must lie in 0..WIDTH");
        end
    endgenerate

    // Per-stage state. Slot k holds the operand pair after slice k has been
    // added. raw_q[k] holds the result bits produced so far, and carry_q[k]
    // holds the carry into slice k+1. The last slot holds the final result.
    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [NSTAGE];
    logic [WIDTH-1:0]  b_q   [NSTAGE];
    logic [WIDTH-1:0]  raw_q [NSTAGE];
    logic              ovf_q;

    logic [NSTAGE-1:0] ready;
    logic [NSTAGE-1:0] up_valid;
    logic [NSTAGE-1:0] nxt_carry;
    logic [WIDTH-1:0]  nxt_a   [NSTAGE];
    logic [WIDTH-1:0]  nxt_b   [NSTAGE];
    logic [WIDTH-1:0]  nxt_raw [NSTAGE];
    logic              nxt_ovf;

    // Ready propagates backwards from the consumer. in_ready is therefore
    // combinational from out_ready through every full stage.
    always_comb begin : ready_chain
        ready[LAST] = !valid_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k + 1];
        end
    end

    always_comb begin : datapath
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_raw;
        logic             src_c;
        logic [CHUNK:0]   part;
        for (int k = 0; k < NSTAGE; k++) begin
            if (k == 0) begin
                // Subtraction is A + ~B + 1. The +1 enters as the carry-in of slice 0.
                src_a       = addend1;
                src_b       = sub ? ~addend2 : addend2;
                src_raw     = '0;
                src_c       = sub;
                up_valid[k] = in_valid;
            end else begin
                src_a       = a_q[k - 1];
                src_b       = b_q[k - 1];
                src_raw     = raw_q[k - 1];
                src_c       = carry_q[k - 1];
                up_valid[k] = valid_q[k - 1];
            end
            part = {1'b0, src_a[k*CHUNK +: CHUNK]} + {1'b0, src_b[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c};
            nxt_a[k]                    = src_a;
            nxt_b[k]                    = src_b;
            nxt_raw[k]                  = src_raw;
            nxt_raw[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            nxt_carry[k]                = part[CHUNK];
        end

        // Signed overflow: the operands share a sign and the result's sign differs from it.
        nxt_ovf = (nxt_a[LAST][WIDTH-1] == nxt_b[LAST][WIDTH-1])
               && (nxt_raw[LAST][WIDTH-1] != nxt_a[LAST][WIDTH-1]);
        if (SATURATE && nxt_ovf) begin
            nxt_raw[LAST] = nxt_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // NOTE: state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would shoot data through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            // NOTE: the data slots are reset as well, not just the valids,
            // because sum must read 0 during and after reset.
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                raw_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= up_valid[k];
                    // Data loads only with a real item. A bubble leaves the
                    // slot (and so the outputs) untouched.
                    if (up_valid[k]) begin
                        a_q[k]     <= nxt_a[k];
                        b_q[k]     <= nxt_b[k];
                        raw_q[k]   <= nxt_raw[k];
                        carry_q[k] <= nxt_carry[k];
                    end
                end
            end
            if (ready[LAST] && up_valid[LAST]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[LAST];
    assign sum       = raw_q[LAST];
    assign carry_out = carry_q[LAST];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_addsub_pipe
//   Bench for fixed_point_addsub_pipe at WIDTH=64, CHUNK=16. Two instances
//   share all inputs: one with SATURATE=1 and one with SATURATE=0. The bench
//   covers directed arithmetic vectors, streaming under different out_ready
//   patterns (checked against a 65-bit reference model), and a mid-cycle reset
//   with operations in flight.
// -----------------------------------------------------------------------------
module tb_fixed_point_addsub_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready, in_ready_w;
    logic [W-1:0] addend1, addend2;
    logic         sub;
    logic         out_valid, out_valid_w;
    logic         out_ready;
    logic [W-1:0] sum, sum_w;
    logic         carry_out, carry_out_w;
    logic         overflow, overflow_w;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] va [48];
    logic [W-1:0] vb [48];
    logic         vs [48];

    always #5 clk = ~clk;

    fixed_point_addsub_pipe #(.WIDTH(64), .FRAC_BITS(32), .CHUNK(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .addend1(addend1), .addend2(addend2), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    fixed_point_addsub_pipe #(.WIDTH(64), .FRAC_BITS(32), .CHUNK(16), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .addend1(addend1), .addend2(addend2), .sub(sub),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .sum(sum_w), .carry_out(carry_out_w), .overflow(overflow_w)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {carry_out, overflow, sum}, computed as one 65-bit addition.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input bit sat);
        logic [W-1:0] be;
        logic [W:0]   r;
        logic         ovf;
        logic [W-1:0] res;
        be  = s ? ~b : b;
        r   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s};
        ovf = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        res = r[W-1:0];
        if (sat && ovf) res = a[W-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        return {r[W], ovf, res};
    endfunction

    // One operation into an empty pipe. Checks the latency and every result
    // field of both instances against hand-computed values.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] exp_sat,
                            input logic [W-1:0] exp_wrap, input logic exp_c, input logic exp_o);
        int lat;
        @(negedge clk);
        addend1 = a; addend2 = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " sum_sat"}, sum, exp_sat);
        check({tag, " sum_wrap"}, sum_w, exp_wrap);
        check({tag, " carry_out"}, carry_out, exp_c);
        check({tag, " overflow"}, overflow, exp_o);
        check({tag, " overflow_wrap"}, overflow_w, exp_o);
        check({tag, " out_valid_wrap"}, out_valid_w, 1);
    endtask

    // Streams n vectors starting at base.
    //   mode 0: out_ready held 1
    //   mode 1: out_ready 0 for the first 10 cycles, then 1
    //   mode 2: out_ready random
    task automatic run_stream(input string tag, input int base, input int n, input int mode);
        logic [W+1:0] exp_q [$];
        logic [W-1:0] expw_q [$];
        logic [W+1:0] e;
        logic [W-1:0] ew;
        logic [W-1:0] held;
        logic         held_v;
        int sent, got, cyc, first_out, last_out, acc_stall;
        sent = 0; got = 0; cyc = 0; first_out = -1; last_out = -1; acc_stall = 0;
        held_v = 1'b0; held = '0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            if (held_v) begin
                check($sformatf("%s hold valid c%0d", tag, cyc), out_valid, 1);
                check($sformatf("%s hold sum c%0d", tag, cyc), sum, held);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc >= 10);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (sent < n) begin
                in_valid = 1'b1;
                addend1  = va[base + sent];
                addend2  = vb[base + sent];
                sub      = vs[base + sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (mode == 1 && cyc == 9) check({tag, " in_ready low when full"}, in_ready, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(addend1, addend2, sub, 1'b1));
                ew = model(addend1, addend2, sub, 1'b0);
                expw_q.push_back(ew[W-1:0]);
                if (mode == 1 && cyc < 10) acc_stall++;
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected result"}, 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ew = expw_q.pop_front();
                    check($sformatf("%s sum #%0d", tag, got), sum, e[W-1:0]);
                    check($sformatf("%s ovf #%0d", tag, got), overflow, e[W]);
                    check($sformatf("%s cout #%0d", tag, got), carry_out, e[W+1]);
                    check($sformatf("%s sum_wrap #%0d", tag, got), sum_w, ew);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = sum;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " results received"}, got, n);
        if (mode == 0) check({tag, " back-to-back span"}, last_out - first_out, n - 1);
        if (mode == 1) check({tag, " accepted while stalled"}, acc_stall, 4);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; addend1 = '0; addend2 = '0; sub = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 48; i++) begin
            va[i] = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
            vb[i] = 64'hC2B2_AE3D_27D4_EB4F * 64'(i + 7);
            vs[i] = (i % 3 == 1);
        end
        va[5]  = 64'h7FFF_FFFF_FFFF_FFFF; vb[5]  = 64'd1;                  vs[5]  = 1'b0;
        va[20] = 64'h8000_0000_0000_0000; vb[20] = 64'd1;                  vs[20] = 1'b1;
        va[33] = 64'hFFFF_FFFF_FFFF_FFFF; vb[33] = 64'd1;                  vs[33] = 1'b0;

        #12;
        check("reset out_valid", out_valid, 0);
        check("reset sum", sum, 0);
        check("reset carry_out", carry_out, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready, 1);

        directed("one_plus_half", 64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000, 1'b0,
                 64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 1'b0, 1'b0);
        directed("carry_all_chunks", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                 64'd0, 64'd0, 1'b1, 1'b0);
        directed("carry_to_int", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
                 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        directed("chunk_carries", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                 64'h0001_0000_0001_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
        directed("pos_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        directed("neg_overflow_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        directed("five_minus_seven", 64'd5, 64'd7, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        directed("zero_minus_zero", 64'd0, 64'd0, 1'b1,
                 64'd0, 64'd0, 1'b1, 1'b0);
        directed("min_plus_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1);

        run_stream("stream_full", 0, 16, 0);
        run_stream("stream_stall", 16, 12, 1);
        run_stream("stream_random", 28, 20, 2);

        // Reset with three operations in flight, the oldest already presented.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addend1 = 64'(i + 1); addend2 = 64'h10; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset out_valid", out_valid, 1);
        check("pre-reset sum", sum, 64'h11);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset sum", sum, 0);
        check("mid reset carry_out", carry_out, 0);
        check("mid reset overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post reset in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no stale results", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
